decoder_sweep_misr: RTL and testbench

//  Self-running stimulus sequencer and signature compactor for the Decoder1/2/3 chain.

---
 rtl/decoder_sweep_misr.sv | 105 ++++++++++
 tb/tb_decoder_sweep_misr.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/decoder_sweep_misr.sv
// decoder_sweep_misr: sweeps a packed decoder stimulus counter, drives dual-rail a_o, compacts resp_i into a MISR.
// Defining DECODER_SWEEP_TRACE_EN adds a valid/ready trace port that gates each sample.
module decoder_sweep_misr #(
  parameter int CNT_W = 15,
  parameter int RESP_W = 211,
  parameter int SIG_W = 32,
  parameter logic [SIG_W-1:0] POLY = SIG_W'(32'h04C11DB7),
  parameter logic [SIG_W-1:0] SEED = '0,
  parameter int SETTLE = 1,
  localparam int EXT_W = CNT_W > 15 ? CNT_W - 15 : 1
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [CNT_W-1:0]  lo_i,
  input  logic [CNT_W-1:0]  hi_i,
  input  logic [RESP_W-1:0] resp_i,
  output logic [25:0]       a_o,
  output logic [EXT_W-1:0]  ext_o,
  output logic [CNT_W-1:0]  cnt_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [SIG_W-1:0]  sig_o
`ifdef DECODER_SWEEP_TRACE_EN
  ,
  output logic              trace_valid_o,
  input  logic              trace_ready_i,
  output logic [CNT_W-1:0]  trace_cnt_o,
  output logic [RESP_W-1:0] trace_resp_o
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int ST_W = SETTLE > 0 ? $clog2(SETTLE + 1) : 1;
  localparam int NCH = (RESP_W + SIG_W - 1) / SIG_W;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, hi_q;
  logic [ST_W-1:0] settle;
  logic [SIG_W-1:0] fold, sig_n;
  logic [NCH*SIG_W-1:0] pad;
  logic at_sample, sample, err;
  assign at_sample = state == RUN && settle == ST_W'(SETTLE);
`ifdef DECODER_SWEEP_TRACE_EN
  assign trace_valid_o = at_sample;
  assign trace_cnt_o = cnt;
  assign trace_resp_o = resp_i;
  assign sample = at_sample && trace_ready_i && !abort_i;
`else
  assign sample = at_sample && !abort_i;
`endif
  // Odd rails carry {intr, cb, IR[7:0], state[2:0]} MSB first; even rails are the complements.
  for (genvar k = 0; k < 13; k++) begin : g_a
    assign a_o[2*k+1] = cnt[14-k];
    assign a_o[2*k] = ~cnt[14-k];
  end
  if (CNT_W > 15) begin : g_ext
    assign ext_o = cnt[CNT_W-1:15];
  end else begin : g_noext
    assign ext_o = 1'b0;
  end
  always_comb begin
    pad = (NCH*SIG_W)'(resp_i);
    fold = '0;
    for (int i = 0; i < NCH; i++) fold = fold ^ pad[i*SIG_W +: SIG_W];
  end
  assign sig_n = {sig_o[SIG_W-2:0], 1'b0} ^ (sig_o[SIG_W-1] ? POLY : '0) ^ fold;
  assign cnt_o = cnt;
  assign busy_o = state == RUN;
  assign done_o = state == DONE;
  assign err_o = err;
  always_comb begin
    state_n = state;
    if (abort_i) state_n = IDLE;
    else if (state != RUN) state_n = start_i ? (hi_i < lo_i ? DONE : RUN) : state;
    else if (sample && cnt == hi_q) state_n = DONE;
  end
  always_ff @(posedge CLK or negedge nRESET)
    if (!nRESET) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge CLK or negedge nRESET)
    if (!nRESET) begin
      cnt <= '0;
      hi_q <= '0;
      settle <= '0;
      sig_o <= SEED;
      err <= 1'b0;
    end else if (!abort_i) begin
      if (state != RUN) begin
        if (start_i) begin
          hi_q <= hi_i;
          sig_o <= SEED;
          settle <= '0;
          err <= hi_i < lo_i;
          if (!(hi_i < lo_i)) cnt <= lo_i;
        end
      end else if (sample) begin
        sig_o <= sig_n;
        if (cnt != hi_q) begin
          cnt <= cnt + 1'b1;
          settle <= '0;
        end
      end else if (!at_sample) settle <= settle + 1'b1;
    end
endmodule

// File: tb/tb_decoder_sweep_misr.sv
// tb_decoder_sweep_misr: directed and randomized sweeps of decoder_sweep_misr against a behavioural signature model.
module tb_decoder_sweep_misr;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  int errors = 0, checks = 0;
  logic [31:0] key = '0;
  logic zr = 1'b0;
  logic s1 = 0, ab1 = 0, b1, d1, e1;
  logic [14:0] lo1 = 0, hi1 = 0, c1;
  logic [210:0] r1;
  logic [25:0] a1;
  logic [0:0] x1;
  logic [31:0] g1;
  logic s0 = 0, b0, d0, e0;
  logic [14:0] lo0 = 0, hi0 = 0, c0;
  logic [210:0] r0;
  logic [25:0] a0;
  logic [0:0] x0;
  logic [31:0] g0;
`ifdef DECODER_SWEEP_TRACE_EN
  logic tv1, tv0;
  logic [14:0] tc1, tc0;
  logic [210:0] tr1, tr0;
`endif

  function automatic logic [25:0] vec_of(input logic [14:0] v);
    logic [12:0] f;
    logic [25:0] a;
    f = {v[14], v[13], v[12:5], v[4:2]};
    for (int k = 0; k < 13; k++) begin
      a[2*k+1] = f[12-k];
      a[2*k] = !f[12-k];
    end
    return a;
  endfunction

  function automatic logic [210:0] resp_of(input logic [25:0] a, input logic [31:0] k);
    logic [210:0] r;
    for (int i = 0; i < 211; i++)
      r[i] = a[(i*7 + int'(k[4:0])) % 26] ^ (a[(i*11 + 3) % 26] & a[i % 26]) ^ k[i % 32];
    return r;
  endfunction

  function automatic logic [31:0] model_sig(input int lo, input int hi, input logic [31:0] k);
    logic [31:0] s, f;
    logic [210:0] r;
    s = '0;
    for (int v = lo; v <= hi; v++) begin
      r = resp_of(vec_of(15'(v)), k);
      f = '0;
      for (int i = 0; i < 211; i++) f[i % 32] = f[i % 32] ^ r[i];
      s = (s << 1) ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ f;
    end
    return s;
  endfunction

  assign r1 = zr ? '0 : resp_of(a1, key);
  assign r0 = resp_of(a0, key);

  decoder_sweep_misr #(.SETTLE(1)) u1 (
    .CLK(clk), .nRESET(rst_n), .start_i(s1), .abort_i(ab1), .lo_i(lo1), .hi_i(hi1),
    .resp_i(r1), .a_o(a1), .ext_o(x1), .cnt_o(c1), .busy_o(b1), .done_o(d1), .err_o(e1), .sig_o(g1)
`ifdef DECODER_SWEEP_TRACE_EN
    , .trace_valid_o(tv1), .trace_ready_i(1'b1), .trace_cnt_o(tc1), .trace_resp_o(tr1)
`endif
  );
  decoder_sweep_misr #(.SETTLE(0)) u0 (
    .CLK(clk), .nRESET(rst_n), .start_i(s0), .abort_i(1'b0), .lo_i(lo0), .hi_i(hi0),
    .resp_i(r0), .a_o(a0), .ext_o(x0), .cnt_o(c0), .busy_o(b0), .done_o(d0), .err_o(e0), .sig_o(g0)
`ifdef DECODER_SWEEP_TRACE_EN
    , .trace_valid_o(tv0), .trace_ready_i(1'b1), .trace_cnt_o(tc0), .trace_resp_o(tr0)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic start(input bit sel, input int lo, input int hi);
    if (sel) begin lo0 = 15'(lo); hi0 = 15'(hi); s0 = 1; end
    else begin lo1 = 15'(lo); hi1 = 15'(hi); s1 = 1; end
    tick();
    s0 = 0;
    s1 = 0;
  endtask

  task automatic wait_done(input bit sel, input int lim, output int cyc);
    cyc = 1;
    while (!(sel ? d0 : d1) && cyc < lim) begin
      tick();
      cyc++;
    end
  endtask

  task automatic sweep1(input string tag, input int lo, input int hi);
    int cyc;
    start(0, lo, hi);
    wait_done(0, 2000, cyc);
    chk({tag, " cycles"}, 64'(cyc), 64'(1 + (hi - lo + 1) * 2));
    chk({tag, " sig"}, g1, model_sig(lo, hi, key));
    chk({tag, " cnt"}, c1, 64'(hi));
    chk({tag, " err"}, e1, 0);
    chk({tag, " busy"}, b1, 0);
  endtask

  initial begin
    int lo, hi, cyc, n;
    logic [31:0] held;
    tick(2);
    chk("rst cnt", c1, 0);
    chk("rst sig", g1, 0);
    chk("rst busy", b1, 0);
    chk("rst done", d1, 0);
    chk("rst err", e1, 0);
    chk("rst a_o", a1, vec_of(15'd0));
    rst_n = 1;
    tick();
    // single vector with zero response
    zr = 1;
    start(0, 5, 5);
    chk("t1 busy@1", b1, 1);
    chk("t1 a_o", a1, vec_of(15'd5));
    tick();
    chk("t1 busy@2", b1, 1);
    chk("t1 done@2", d1, 0);
    tick();
    chk("t1 done@3", d1, 1);
    chk("t1 sig", g1, 0);
    chk("t1 cnt", c1, 5);
    zr = 0;
    // rail mapping of a known vector
    start(0, 15'h1FE4, 15'h1FE4);
    chk("t4 a_o", a1, 26'h25AAAA5);
    tick(2);
    chk("t4 done", d1, 1);
    // inverted range
    start(0, 9, 3);
    chk("t3 done", d1, 1);
    chk("t3 err", e1, 1);
    chk("t3 sig", g1, 0);
    chk("t3 cnt", c1, 15'h1FE4);
    chk("t3 a_o", a1, 26'h25AAAA5);
    // randomized and boundary ranges
    for (int t = 0; t < 4; t++) begin
      key = $urandom;
      lo = int'($urandom_range(0, 32700));
      hi = lo + int'($urandom_range(0, 40));
      sweep1("rand", lo, hi);
    end
    sweep1("top", 32767, 32767);
    sweep1("zero", 0, 0);
    // abort on a sample cycle
    key = $urandom;
    lo = int'($urandom_range(0, 1000));
    start(0, lo, lo + 10);
    n = 0;
    while (c1 != 15'(lo + 2) && n < 100) begin tick(); n++; end
    chk("t5 reach", 64'(n < 100), 1);
    tick();
    ab1 = 1;
    tick();
    ab1 = 0;
    held = model_sig(lo, lo + 1, key);
    chk("t5 busy", b1, 0);
    chk("t5 done", d1, 0);
    chk("t5 sig", g1, held);
    tick(3);
    chk("t5 frozen", g1, held);
    start(0, lo, lo + 3);
    chk("t5 reseed", g1, 0);
    wait_done(0, 100, cyc);
    chk("t5 cycles", 64'(cyc), 9);
    chk("t5 resig", g1, model_sig(lo, lo + 3, key));
    // asynchronous reset mid-sweep
    start(0, 100, 200);
    tick(10);
    rst_n = 0;
    #1;
    chk("arst sig", g1, 0);
    chk("arst busy", b1, 0);
    chk("arst cnt", c1, 0);
    tick();
    rst_n = 1;
    tick();
    // full range with no settle cycles
    key = $urandom;
    start(1, 0, 15'h7FFF);
    wait_done(1, 40000, cyc);
    chk("t2 cycles", 64'(cyc), 32769);
    chk("t2 sig", g0, model_sig(0, 32767, key));
    chk("t2 cnt", c0, 15'h7FFF);
    chk("t2 err", e0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
